operand_mux_rf: RTL

//   Parametrised register file plus registered operand selector for the bitty datapath.

---
 rtl/operand_mux_rf.sv | 128 ++++++++++++
 1 files changed

// File: rtl/operand_mux_rf.sv
// operand_mux_rf
//   Register file plus registered operand selector for the bitty datapath.
//   Holds N_REGS general registers. Each cycle it selects one operand from a
//   register, the immediate, the default value, or zero, and presents that
//   operand one cycle later. The selection step forwards a same-cycle register
//   write to the operand (write-to-read bypass).
//
// Ports
//   clk_i        rising-edge clock
//   reset_i      synchronous, active-high reset
//   wr_en_i      register write strobe
//   wr_addr_i    register index to write
//   wr_data_i    write data
//   immediate_i  immediate operand from decode
//   def_val_i    default operand value
//   mux_sel_i    operand source select
//   sel_valid_i  mux_sel_i/immediate_i valid this cycle
//   stall_i      downstream not ready; output stage holds
//   mux_out_o    registered operand
//   out_valid_o  mux_out_o holds a valid operand
//   reg_dbg_o    flat register contents, reg i at [i*DATA_W +: DATA_W]
module operand_mux_rf #(
  parameter int DATA_W  = 16,
  parameter int N_REGS  = 8,
  parameter int SEL_W   = 4,
  parameter int R0_ZERO = 0
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     wr_en_i,
  input  logic [SEL_W-1:0]         wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic [DATA_W-1:0]        immediate_i,
  input  logic [DATA_W-1:0]        def_val_i,
  input  logic [SEL_W-1:0]         mux_sel_i,
  input  logic                     sel_valid_i,
  input  logic                     stall_i,
  output logic [DATA_W-1:0]        mux_out_o,
  output logic                     out_valid_o,
  output logic [N_REGS*DATA_W-1:0] reg_dbg_o
);

  localparam logic [SEL_W-1:0] SEL_IMM = SEL_W'(N_REGS);
  localparam logic [SEL_W-1:0] SEL_DEF = SEL_W'(N_REGS + 1);

  logic [DATA_W-1:0] regs_q [N_REGS];
  logic [DATA_W-1:0] regs_d [N_REGS];
  logic [DATA_W-1:0] mux_out_q, mux_out_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] next_op;
  logic              wr_hit;

  // A write is accepted only for an in-range index. With a hardwired r0 the
  // write to index 0 is dropped, so the bypass below never forwards to r0.
  always_comb begin
    wr_hit = wr_en_i && (wr_addr_i < SEL_IMM);
    if ((R0_ZERO != 0) && (wr_addr_i == '0)) begin
      wr_hit = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < N_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_hit && (wr_addr_i == SEL_W'(i))) begin
        regs_d[i] = wr_data_i;
      end
    end
  end

  always_comb begin
    next_op = '0;
    if (mux_sel_i < SEL_IMM) begin
      for (int i = 0; i < N_REGS; i++) begin
        if (mux_sel_i == SEL_W'(i)) begin
          next_op = regs_q[i];
        end
      end
      if (wr_hit && (wr_addr_i == mux_sel_i)) begin
        next_op = wr_data_i;
      end
      // r0 is never written when hardwired, but force it here too so the
      // read stays zero independently of the storage contents.
      if ((R0_ZERO != 0) && (mux_sel_i == '0)) begin
        next_op = '0;
      end
    end else if (mux_sel_i == SEL_IMM) begin
      next_op = immediate_i;
    end else if (mux_sel_i == SEL_DEF) begin
      next_op = def_val_i;
    end
  end

  // Held operand is not refreshed by later writes: the stage only loads
  // next_op when not stalled.
  always_comb begin
    mux_out_d   = mux_out_q;
    out_valid_d = out_valid_q;
    if (!stall_i) begin
      mux_out_d   = next_op;
      out_valid_d = sel_valid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < N_REGS; i++) begin
        regs_q[i] <= '0;
      end
      mux_out_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      mux_out_q   <= mux_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign mux_out_o   = mux_out_q;
  assign out_valid_o = out_valid_q;

  for (genvar g = 0; g < N_REGS; g++) begin : g_dbg
    assign reg_dbg_o[g*DATA_W +: DATA_W] = regs_q[g];
  end

endmodule
